fifo_burst_reader: RTL and testbench

Read-side master for the synchronous FIFO (depth 8, width 16). It drains a requested number of words from the FIFO and presents them on a downstream valid/ready stream. It absorbs the FIFO's 1-cycle read latency and downstream backpressure with a 2-entry skid buffer. It sits between the FIFO's read port and the consuming datapath. Bursts are started by a control pulse and finish with a done pulse.

---
 rtl/fifo_burst_reader_if.sv | 30 +++
 rtl/fifo_burst_reader.sv | 168 ++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// Bundles the burst control, FIFO read port and downstream stream of fifo_burst_reader.
// The master modport is the reader's side. The slave modport is the FIFO/consumer/controller side.
interface fifo_burst_reader_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int LEN_W      = 8
);
  logic                  start;
  logic [LEN_W-1:0]      burst_len;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_dout;
  logic                  fifo_underflow;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic                  underflow_err;

  modport master (
    input  start, burst_len, fifo_empty, fifo_dout, fifo_underflow, m_ready,
    output busy, done, timeout, fifo_rd_en, m_valid, m_data, underflow_err
  );

  modport slave (
    output start, burst_len, fifo_empty, fifo_dout, fifo_underflow, m_ready,
    input  busy, done, timeout, fifo_rd_en, m_valid, m_data, underflow_err
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains burst_len words from a sync FIFO onto a valid/ready stream; FIFO_BURST_READER_TIMEOUT_EN adds an empty-FIFO timeout.
// Latency: first m_valid 2 cycles after start is accepted, then one word per cycle.
// Backpressure: 2-entry skid buffer holds m_valid/m_data while m_ready=0, and reads are throttled so it never overflows.
module fifo_burst_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int LEN_W      = 8
`ifdef FIFO_BURST_READER_TIMEOUT_EN
  ,parameter int TIMEOUT   = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_burst_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      issued_q, issued_d;
  logic [LEN_W-1:0]      delivered_q, delivered_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_count_q, buf_count_d;
  logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
  logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;
  logic                  underflow_err_q, underflow_err_d;

  logic                  busy;
  logic                  push;
  logic                  pop;
  logic                  rd_en;
  logic [2:0]            occ_after_pop;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  to_flag_q, to_flag_d;
`endif

  assign busy = (state_q != IDLE);
  assign push = inflight_q;
  assign pop  = (buf_count_q != 2'd0) && bus.m_ready;

  // Crediting this cycle's pop lets a read issue against a slot that frees now,
  // which is what sustains one word per cycle through a 2-deep buffer.
  assign occ_after_pop = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en = (state_q == READ) && !bus.fifo_empty &&
                 (issued_q < len_q) && (occ_after_pop < 3'd2);

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    issued_d        = issued_q;
    delivered_d     = delivered_q;
    inflight_d      = rd_en;
    buf_count_d     = buf_count_q;
    buf0_d          = buf0_q;
    buf1_d          = buf1_q;
    underflow_err_d = underflow_err_q | (bus.fifo_underflow & busy);
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    to_cnt_d        = to_cnt_q;
    to_flag_d       = to_flag_q;
`endif

    if (pop && push) begin
      if (buf_count_q == 2'd1) begin
        buf0_d = bus.fifo_dout;
      end else begin
        buf0_d = buf1_q;
        buf1_d = bus.fifo_dout;
      end
    end else if (pop) begin
      buf0_d      = buf1_q;
      buf_count_d = buf_count_q - 2'd1;
    end else if (push) begin
      if (buf_count_q == 2'd0) buf0_d = bus.fifo_dout;
      else                     buf1_d = bus.fifo_dout;
      buf_count_d = buf_count_q + 2'd1;
    end

    if (rd_en) issued_d = issued_q + 1'b1;
    if (pop)   delivered_d = delivered_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d       = bus.burst_len;
          issued_d    = '0;
          delivered_d = '0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
          to_cnt_d    = '0;
          to_flag_d   = 1'b0;
`endif
          state_d     = (bus.burst_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issued_d == len_q) state_d = DRAIN;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        if (bus.fifo_empty && (issued_q < len_q)) begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_d == TO_W'(TIMEOUT)) begin
            state_d   = DRAIN;
            to_flag_d = 1'b1;
          end
        end else begin
          to_cnt_d = '0;
        end
`endif
      end
      DRAIN: begin
        // Exit on next-cycle occupancy so done lands right after the last beat.
        if (!inflight_d && (buf_count_d == 2'd0) && (delivered_d == issued_q))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      len_q           <= '0;
      issued_q        <= '0;
      delivered_q     <= '0;
      inflight_q      <= 1'b0;
      buf_count_q     <= 2'd0;
      buf0_q          <= '0;
      buf1_q          <= '0;
      underflow_err_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      delivered_q     <= delivered_d;
      inflight_q      <= inflight_d;
      buf_count_q     <= buf_count_d;
      buf0_q          <= buf0_d;
      buf1_q          <= buf1_d;
      underflow_err_q <= underflow_err_d;
    end
  end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign bus.timeout = (state_q == DONE) && to_flag_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.busy          = busy;
  assign bus.done          = (state_q == DONE);
  assign bus.fifo_rd_en    = rd_en;
  assign bus.m_valid       = (buf_count_q != 2'd0);
  assign bus.m_data        = buf0_q;
  assign bus.underflow_err = underflow_err_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural 8x16 FIFO on the read side, scoreboard of written words on the stream side.
module tb_fifo_burst_reader;

  logic clk;
  logic rst_n;

  fifo_burst_reader_if #(.FIFO_WIDTH(16), .LEN_W(8)) intf();

  fifo_burst_reader #(.FIFO_WIDTH(16), .LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural source FIFO: depth 8, registered read data one cycle after rd_en.
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] fmem [8];
  logic [3:0]  fcnt;
  logic [2:0]  fwp, frp;
  logic [15:0] fdout;
  logic        funder;
  logic        do_rd, do_wr;

  assign do_rd = intf.fifo_rd_en && (fcnt != 4'd0);
  assign do_wr = wr_en && ((fcnt != 4'd8) || do_rd);
  assign intf.fifo_empty     = (fcnt == 4'd0);
  assign intf.fifo_dout      = fdout;
  assign intf.fifo_underflow = funder;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= 4'd0; fwp <= 3'd0; frp <= 3'd0; fdout <= 16'd0; funder <= 1'b0;
    end else begin
      funder <= intf.fifo_rd_en && (fcnt == 4'd0);
      if (do_rd) begin
        fdout <= fmem[frp];
        frp   <= frp + 3'd1;
      end
      if (do_wr) begin
        fmem[fwp] <= wr_data;
        fwp       <= fwp + 3'd1;
      end
      fcnt <= fcnt + {3'b000, do_wr} - {3'b000, do_rd};
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] exp_q [$];
  int          beat_cyc_q [$];
  int          rd_total = 0;
  int          beat_total = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  int          last_rd_cyc = 0;
  logic        to_at_done = 1'b0;
  int          outstanding = 0;
  logic        stalled = 1'b0;
  logic [15:0] stall_dat = 16'd0;

  // Stream monitor: scoreboard compare on every accepted beat, plus hold and occupancy checks.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (!rst_n) begin
      outstanding = 0;
      stalled     = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (!intf.m_valid || intf.m_data !== stall_dat) begin
          errors++;
          $display("FAIL hold_stable cyc=%0d got valid=%0b data=%h want valid=1 data=%h",
                   cyc, intf.m_valid, intf.m_data, stall_dat);
        end
      end
      if (intf.fifo_rd_en) begin
        rd_total++;
        last_rd_cyc = cyc;
        checks++;
        if (intf.fifo_empty) begin
          errors++;
          $display("FAIL rd_while_empty cyc=%0d got rd_en=1 with empty=1 want no read", cyc);
        end
      end
      if (intf.m_valid && intf.m_ready) begin
        beat_total++;
        beat_cyc_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected cyc=%0d got data=%h want no beat", cyc, intf.m_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (intf.m_data !== exp_w) begin
            errors++;
            $display("FAIL beat_data cyc=%0d got %h want %h", cyc, intf.m_data, exp_w);
          end
        end
      end
      outstanding = outstanding + (intf.fifo_rd_en ? 1 : 0) - ((intf.m_valid && intf.m_ready) ? 1 : 0);
      if (intf.fifo_rd_en) begin
        checks++;
        if (outstanding > 2) begin
          errors++;
          $display("FAIL occupancy cyc=%0d got %0d want <=2", cyc, outstanding);
        end
      end
      stalled   = intf.m_valid && !intf.m_ready;
      stall_dat = intf.m_data;
      if (intf.start && !intf.busy) start_cyc = cyc;
      if (intf.done) begin
        done_cnt++;
        done_cyc   = cyc;
        to_at_done = intf.timeout;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 16'(i);
      exp_q.push_back(base + 16'(i));
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic start_burst(input logic [7:0] len);
    intf.start     = 1'b1;
    intf.burst_len = len;
    step();
    intf.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic toggle);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      step();
      if (toggle) intf.m_ready = !intf.m_ready;
    end
    intf.m_ready = 1'b1;
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_wait got no done within %0d cycles want done pulse", budget);
    end
  endtask

  task automatic test_reset();
    int d0;
    checks++;
    if ({intf.fifo_rd_en, intf.m_valid, intf.busy, intf.done, intf.timeout, intf.underflow_err} !== 6'b0 ||
        intf.m_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%0b v=%0b busy=%0b done=%0b to=%0b uf=%0b data=%h want all 0",
               intf.fifo_rd_en, intf.m_valid, intf.busy, intf.done, intf.timeout, intf.underflow_err, intf.m_data);
    end
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (intf.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %0b want 0", intf.busy);
    end
    // Abort a live burst with an asynchronous mid-cycle reset.
    write_words(4, 16'h0100);
    start_burst(8'd4);
    step(); step();
    d0 = done_cnt;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({intf.fifo_rd_en, intf.m_valid, intf.busy, intf.done, intf.timeout, intf.underflow_err} !== 6'b0 ||
        intf.m_data !== 16'd0) begin
      errors++;
      $display("FAIL midburst_reset got rd=%0b v=%0b busy=%0b done=%0b to=%0b uf=%0b data=%h want all 0",
               intf.fifo_rd_en, intf.m_valid, intf.busy, intf.done, intf.timeout, intf.underflow_err, intf.m_data);
    end
    step(); step();
    rst_n = 1'b1;
    exp_q.delete();
    step(); step(); step();
    checks++;
    if (intf.busy !== 1'b0 || intf.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%0b valid=%0b want 0 0", intf.busy, intf.m_valid);
    end
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL reset_no_done got %0d done pulses want 0", done_cnt - d0);
    end
  endtask

  task automatic test_basic();
    int r0 = rd_total;
    int b0 = beat_total;
    write_words(5, 16'h0001);
    beat_cyc_q.delete();
    start_burst(8'd5);
    wait_done(60, 1'b0);
    checks++;
    if (rd_total - r0 != 5) begin
      errors++;
      $display("FAIL basic_reads got %0d want 5", rd_total - r0);
    end
    checks++;
    if (beat_total - b0 != 5 || beat_cyc_q.size() != 5) begin
      errors++;
      $display("FAIL basic_beats got %0d want 5", beat_total - b0);
    end else begin
      checks++;
      if (beat_cyc_q[0] - start_cyc != 3 || beat_cyc_q[4] - beat_cyc_q[0] != 4) begin
        errors++;
        $display("FAIL basic_timing got first=+%0d span=%0d want first=+3 span=4",
                 beat_cyc_q[0] - start_cyc, beat_cyc_q[4] - beat_cyc_q[0]);
      end
      checks++;
      if (done_cyc - beat_cyc_q[4] != 1) begin
        errors++;
        $display("FAIL basic_done_lag got %0d want 1", done_cyc - beat_cyc_q[4]);
      end
    end
    checks++;
    if (intf.fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL basic_fifo_empty got %0b want 1", intf.fifo_empty);
    end
  endtask

  task automatic test_backpressure();
    int r0 = rd_total;
    int b0 = beat_total;
    write_words(8, 16'hA000);
    start_burst(8'd8);
    wait_done(100, 1'b1);
    checks++;
    if (rd_total - r0 != 8 || beat_total - b0 != 8) begin
      errors++;
      $display("FAIL bp_counts got reads=%0d beats=%0d want 8 8", rd_total - r0, beat_total - b0);
    end
    checks++;
    if (intf.underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_underflow got %0b want 0", intf.underflow_err);
    end
  endtask

  task automatic test_empty_stall();
    int b0 = beat_total;
    write_words(1, 16'h5000);
    start_burst(8'd3);
    repeat (10) step();
    write_words(2, 16'h5001);
    wait_done(60, 1'b0);
    checks++;
    if (beat_total - b0 != 3) begin
      errors++;
      $display("FAIL stall_beats got %0d want 3", beat_total - b0);
    end
    checks++;
    if (to_at_done !== 1'b0) begin
      errors++;
      $display("FAIL stall_timeout got %0b want 0", to_at_done);
    end
  endtask

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  task automatic test_timeout();
    int b0 = beat_total;
    write_words(2, 16'h7000);
    start_burst(8'd4);
    wait_done(100, 1'b0);
    checks++;
    if (beat_total - b0 != 2 || to_at_done !== 1'b1) begin
      errors++;
      $display("FAIL timeout_end got beats=%0d timeout=%0b want 2 1", beat_total - b0, to_at_done);
    end
    // 16 empty READ cycles after the last read, one DRAIN cycle, then DONE.
    checks++;
    if (done_cyc - last_rd_cyc != 18) begin
      errors++;
      $display("FAIL timeout_lag got %0d want 18", done_cyc - last_rd_cyc);
    end
  endtask
`endif

  task automatic test_zero_and_ignored();
    int r0 = rd_total;
    int b0;
    start_burst(8'd0);
    wait_done(10, 1'b0);
    checks++;
    if (done_cyc - start_cyc != 1 || rd_total != r0) begin
      errors++;
      $display("FAIL zero_len got lag=%0d reads=%0d want 1 0", done_cyc - start_cyc, rd_total - r0);
    end
    step();
    r0 = rd_total;
    b0 = beat_total;
    write_words(2, 16'h3000);
    start_burst(8'd2);
    intf.start     = 1'b1;
    intf.burst_len = 8'd5;
    step();
    intf.start = 1'b0;
    wait_done(40, 1'b0);
    repeat (6) step();
    checks++;
    if (rd_total - r0 != 2 || beat_total - b0 != 2 || intf.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start got reads=%0d beats=%0d busy=%0b want 2 2 0",
               rd_total - r0, beat_total - b0, intf.busy);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    wr_en          = 1'b0;
    wr_data        = 16'd0;
    intf.start     = 1'b0;
    intf.burst_len = 8'd0;
    intf.m_ready   = 1'b1;
    step(); step();
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    test_timeout();
`endif
    test_zero_and_ignored();
    checks++;
    if (exp_q.size() != 0 || intf.underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL final_state got leftover=%0d underflow_err=%0b want 0 0", exp_q.size(), intf.underflow_err);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish by 200us want finish");
    $fatal(1, "watchdog");
  end

endmodule
